// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue in front of a register file.
// Holds up to DEPTH pending {reg, data} writes and presents the oldest one to the register file.
// Two lookup ports forward the youngest pending value for a register index.
// Optional macro WBQ_ZERO_DROP_EN: writes to register 0 complete the handshake but are discarded,
// and lookups of index 0 never hit.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_reg,
    input  logic [31:0]               in_data,
    output logic                      rf_regWrite,
    output logic [4:0]                rf_write_reg,
    output logic [31:0]               rf_write_data,
    input  logic                      rf_ready,
    input  logic [4:0]                lookup_reg1,
    input  logic [4:0]                lookup_reg2,
    output logic                      hit1,
    output logic                      hit2,
    output logic [31:0]               fwd_data1,
    output logic [31:0]               fwd_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]       reg_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             enq;
    logic             pop;

    // Handshake decode; in_ready depends only on registered count so it cannot rise on a same-cycle pop.
    always_comb begin
        in_ready = (count < CNT_W'(DEPTH));
        push     = in_valid && in_ready;
`ifdef WBQ_ZERO_DROP_EN
        enq      = push && (in_reg != 5'd0);
`else
        enq      = push;
`endif
        pop      = rf_regWrite && rf_ready;
    end

    // Entry storage; not reset, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            reg_mem[tail]  <= in_reg;
            data_mem[tail] <= in_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Present the head entry; zero fields when empty.
    always_comb begin
        rf_regWrite   = (count != '0);
        rf_write_reg  = '0;
        rf_write_data = '0;
        if (rf_regWrite) begin
            rf_write_reg  = reg_mem[head];
            rf_write_data = data_mem[head];
        end
    end

    // Forwarding lookup: walk oldest to youngest so the youngest match wins.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (reg_mem[head + PTR_W'(i)] == lookup_reg1) begin
                    hit1      = 1'b1;
                    fwd_data1 = data_mem[head + PTR_W'(i)];
                end
                if (reg_mem[head + PTR_W'(i)] == lookup_reg2) begin
                    hit2      = 1'b1;
                    fwd_data2 = data_mem[head + PTR_W'(i)];
                end
            end
        end
`ifdef WBQ_ZERO_DROP_EN
        if (lookup_reg1 == 5'd0) begin
            hit1      = 1'b0;
            fwd_data1 = '0;
        end
        if (lookup_reg2 == 5'd0) begin
            hit2      = 1'b0;
            fwd_data2 = '0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus random traffic, checked by a
// queue-based reference model that a negedge monitor compares against every cycle.
module tb_regfile_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          rf_regWrite;
    logic [4:0]    rf_write_reg;
    logic [31:0]   rf_write_data;
    logic          rf_ready;
    logic [4:0]    lookup_reg1;
    logic [4:0]    lookup_reg2;
    logic          hit1;
    logic          hit2;
    logic [31:0]   fwd_data1;
    logic [31:0]   fwd_data2;
    logic [CW-1:0] count;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .rf_regWrite   (rf_regWrite),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_ready      (rf_ready),
        .lookup_reg1   (lookup_reg1),
        .lookup_reg2   (lookup_reg2),
        .hit1          (hit1),
        .hit2          (hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lookup: scan pending writes in age order, the last match is the youngest.
    function automatic void ref_lookup(input logic [4:0] r, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
`ifdef WBQ_ZERO_DROP_EN
        if (r == 5'd0) return;
`endif
        foreach (mq[i]) begin
            if (mq[i].r == r) begin
                h = 1'b1;
                d = mq[i].d;
            end
        end
    endfunction

    // Monitor: compare DUT against the model mid-cycle, then apply this cycle's handshakes to the model.
    always @(negedge clk) begin
        logic        eh;
        logic [31:0] ed;
        bit          rdy_m;
        if (mon_en && rst_n) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("rf_regWrite", 32'(rf_regWrite), 32'(mq.size() != 0));
            chk("rf_write_reg", 32'(rf_write_reg), (mq.size() != 0) ? 32'(mq[0].r) : 32'd0);
            chk("rf_write_data", rf_write_data, (mq.size() != 0) ? mq[0].d : 32'd0);
            ref_lookup(lookup_reg1, eh, ed);
            chk("hit1", 32'(hit1), 32'(eh));
            chk("fwd_data1", fwd_data1, ed);
            ref_lookup(lookup_reg2, eh, ed);
            chk("hit2", 32'(hit2), 32'(eh));
            chk("fwd_data2", fwd_data2, ed);
            rdy_m = (mq.size() < DEPTH);
            if (mq.size() != 0 && rf_ready) void'(mq.pop_front());
            if (in_valid && rdy_m) begin
`ifdef WBQ_ZERO_DROP_EN
                if (in_reg != 5'd0) mq.push_back('{r: in_reg, d: in_data});
`else
                mq.push_back('{r: in_reg, d: in_data});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic rdy);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        rf_ready = rdy;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_rf_regWrite"}, 32'(rf_regWrite), 32'd0);
        chk({tag, "_rf_write_reg"}, 32'(rf_write_reg), 32'd0);
        chk({tag, "_rf_write_data"}, rf_write_data, 32'd0);
        chk({tag, "_hit"}, 32'({hit1, hit2}), 32'd0);
        chk({tag, "_fwd_data1"}, fwd_data1, 32'd0);
        chk({tag, "_fwd_data2"}, fwd_data2, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        lookup_reg1 = 5'd0;
        lookup_reg2 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        mon_en = 1'b1;
        #3;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write-back, consumed immediately.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        chk("single_regWrite", 32'(rf_regWrite), 32'd1);
        chk("single_reg", 32'(rf_write_reg), 32'd5);
        chk("single_data", rf_write_data, 32'hDEADBEEF);
        step();
        chk("single_count_after", 32'(count), 32'd0);

        // Fill to full with the register file stalled, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 32'(100 + i), 1'b0);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rf_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_reg", 32'(rf_write_reg), 32'(k));
            step();
        end
        chk("drain_empty", 32'(rf_regWrite), 32'd0);

        // Forwarding picks the youngest of two writes to the same register.
        drive(1'b1, 5'd7, 32'h11, 1'b0);
        step();
        drive(1'b1, 5'd7, 32'h22, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        lookup_reg1 = 5'd7;
        lookup_reg2 = 5'd8;
        #1;
        chk("fwd_hit1", 32'(hit1), 32'd1);
        chk("fwd_data1", fwd_data1, 32'h22);
        chk("fwd_hit2", 32'(hit2), 32'd0);
        chk("fwd_data2", fwd_data2, 32'd0);
        rf_ready = 1'b1;
        step();
        step();

        // Steady push+pop at count 2, crossing the pointer wrap several times.
        drive(1'b1, 5'd10, 32'hA0, 1'b0);
        step();
        drive(1'b1, 5'd11, 32'hA1, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(12 + i), 32'hB0 + 32'(i), 1'b1);
            step();
            chk("steady_count", 32'(count), 32'd2);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        step();
        step();

        // Asynchronous reset with entries pending, then a push on the first edge after release.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 1'b0);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        lookup_reg1 = 5'd20;
        lookup_reg2 = 5'd22;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        mq.delete();
        step();
        rst_n = 1'b1;
        drive(1'b1, 5'd3, 32'h33, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        chk("post_rst_regWrite", 32'(rf_regWrite), 32'd1);
        chk("post_rst_reg", 32'(rf_write_reg), 32'd3);
        step();

        // Write to register 0.
        lookup_reg1 = 5'd0;
        drive(1'b1, 5'd0, 32'h5, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
`ifdef WBQ_ZERO_DROP_EN
        chk("zero_count", 32'(count), 32'd0);
        chk("zero_regWrite", 32'(rf_regWrite), 32'd0);
        chk("zero_hit", 32'(hit1), 32'd0);
`else
        chk("zero_count", 32'(count), 32'd1);
        chk("zero_reg", 32'(rf_write_reg), 32'd0);
        chk("zero_hit", 32'(hit1), 32'd1);
        chk("zero_fwd", fwd_data1, 32'h5);
`endif
        rf_ready = 1'b1;
        step();

        // Random traffic on a narrow register range so lookups hit often.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) != 0));
            lookup_reg1 = 5'($urandom_range(0, 7));
            lookup_reg2 = 5'($urandom_range(0, 7));
            step();
        end

        drive(1'b0, 5'd0, 32'd0, 1'b1);
        repeat (DEPTH + 2) step();
        chk("final_empty", 32'(count), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
